clmul_unit: RTL
===============

// Module: clmul_unit
// PURPOSE
// - Iterative carry-less multiply unit for Zbc: CLMUL, CLMULH, CLMULR.
// - Multi-cycle companion to the single-cycle bit-manipulation unit in the execute stage.
// - Issue side: start pulse with operands. Completion side: one-cycle done pulse.
//   The result is held until the next start.
// PARAMETERS
// - BITS_PER_CYCLE  4  multiplier bits consumed per CALC cycle; legal values 1,2,4,8,16,32
// PORTS
// - s_clk_i      in   1   clock
// - s_resetn_i   in   1   asynchronous active-low reset
// - s_start_i    in   1   start request; accepted only in IDLE or DONE
// - s_flush_i    in   1   abort the current operation (pipeline kill)
// - s_op_i       in   2   00 CLMUL, 01 CLMULH, 10 CLMULR, 11 reserved
// - s_op1_i      in   32  multiplicand a
// - s_op2_i      in   32  multiplier b
// - s_busy_o     out  1   high while in CALC
// - s_done_o     out  1   one-cycle pulse, result valid
// - s_result_o   out  32  result; held from done until the next accepted start
// BEHAVIOUR
// - Reset: state=IDLE; s_busy_o=0; s_done_o=0; s_result_o=0; acc=0; internal regs=0.
// - Arithmetic: P[63:0] = XOR over i in 0..31 of ({32'b0,a} << i) for every i with b[i]=1.
//   CLMUL=P[31:0]; CLMULH=P[63:32]; CLMULR=P[62:31].
// - Start: s_start_i=1 in IDLE/DONE at edge T captures a, b, op, clears acc, enters CALC.
//   N=32/BITS_PER_CYCLE.
// - CALC step: handle bits b[k..k+BPC-1]: acc ^= a<<j for each set bit, k advances by BPC.
//   After N CALC cycles -> DONE.
// - DONE: s_done_o=1 for exactly one cycle (T+N+1); s_result_o updated the same cycle.
//   Next cycle -> IDLE unless a new start is accepted.
// - Back-to-back: start in the DONE cycle is accepted; the next op's done is N+1 cycles later.
// - Reserved op 11: no CALC; DONE at T+1 with s_result_o=0.
// - s_start_i while busy: ignored; no queueing.
// - Flush: IDLE at next edge, no done, s_result_o keeps its old value. Flush beats a
//   simultaneous start.
// - Async reset mid-operation: immediate return to reset values; no done.
// - Operand inputs are sampled only at start; they may change freely during CALC.
// CONFIGURATION
// - CLMUL_ZERO_SKIP_EN defined: CALC goes to DONE once the remaining unprocessed multiplier
//   bits are all zero after the current step.
//   - Minimum latency is 1 CALC cycle (done at T+2).
//   - Results are identical to the non-skip build.
// - Not defined: fixed latency; done always at T+N+1.
// TESTING
// - BPC=4, CLMUL a=3, b=3 -> done at T+9, result 0x00000005.
// - CLMULH a=b=0x80000000 -> 0x40000000.
// - CLMULR a=b=0x80000000 -> 0x80000000.
// - CLMUL then CLMULH, a=b=0xFFFFFFFF, second start issued in the done cycle
//   -> 0x55555555, then 0x55555555; done pulses 9 cycles apart.
// - Flush at T+4 -> no done; s_result_o unchanged; busy=0 from T+5.
//   Start at T+5 completes normally.
// - a=0x12345678, b=1:
//   - with CLMUL_ZERO_SKIP_EN: done at T+2, result 0x12345678.
//   - without: done at T+9, same result.
// - Reset asserted during CALC -> all outputs 0 immediately.
//   Start after release -> correct result at N+1.

Source files
------------

// File: rtl/clmul_unit.sv
// Iterative carry-less multiplier for Zbc (CLMUL, CLMULH, CLMULR), BITS_PER_CYCLE bits per step.
// Optional feature macro CLMUL_ZERO_SKIP_EN: finish as soon as the unprocessed multiplier bits are zero.
module clmul_unit #(
   parameter int unsigned BITS_PER_CYCLE = 4
) (
   input  logic        s_clk_i,
   input  logic        s_resetn_i,
   input  logic        s_start_i,
   input  logic        s_flush_i,
   input  logic [1:0]  s_op_i,
   input  logic [31:0] s_op1_i,
   input  logic [31:0] s_op2_i,
   output logic        s_busy_o,
   output logic        s_done_o,
   output logic [31:0] s_result_o
);

   localparam int unsigned NumSteps = 32 / BITS_PER_CYCLE;
   localparam int unsigned CntW     = $clog2(NumSteps) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(NumSteps - 1);

   localparam logic [1:0] OpClmul  = 2'b00;
   localparam logic [1:0] OpClmulh = 2'b01;
   localparam logic [1:0] OpClmulr = 2'b10;
   localparam logic [1:0] OpRsvd   = 2'b11;

   if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
         BITS_PER_CYCLE == 8 || BITS_PER_CYCLE == 16 || BITS_PER_CYCLE == 32)) begin : g_bpc_check
      $error("BITS_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32");
   end

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StCalc = 2'b01,
      StDone = 2'b10
   } state_e;

   state_e          state_q, state_d;
   logic [63:0]     mcand_q, mcand_d;    // multiplicand, pre-shifted to the current bit position
   logic [31:0]     mplier_q, mplier_d;  // unprocessed multiplier bits, LSB is the next one
   logic [1:0]      op_q, op_d;
   logic [63:0]     acc_q, acc_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     result_q, result_d;

   logic [63:0]     step_acc;
   logic [31:0]     mplier_rem;
   logic            last_step;

   function automatic logic [31:0] sel_result(input logic [1:0] op, input logic [63:0] p);
      logic [31:0] r;
      unique case (op)
         OpClmul:  r = p[31:0];
         OpClmulh: r = p[63:32];
         OpClmulr: r = p[62:31];
         default:  r = '0;
      endcase
      return r;
   endfunction

   // Partial products for the BITS_PER_CYCLE multiplier bits handled this step.
   always_comb begin
      step_acc = acc_q;
      for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
         if (mplier_q[5'(j)]) begin
            step_acc = step_acc ^ (mcand_q << j);
         end
      end
   end

   assign mplier_rem = mplier_q >> BITS_PER_CYCLE;

`ifdef CLMUL_ZERO_SKIP_EN
   assign last_step = (cnt_q == LastCnt) || (mplier_rem == '0);
`else
   assign last_step = (cnt_q == LastCnt);
`endif

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      op_d     = op_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (state_q == StDone) begin
               state_d = StIdle;
            end
            if (s_start_i) begin
               mcand_d  = {32'b0, s_op1_i};
               mplier_d = s_op2_i;
               op_d     = s_op_i;
               acc_d    = '0;
               cnt_d    = '0;
               if (s_op_i == OpRsvd) begin
                  state_d  = StDone;
                  result_d = '0;
               end else begin
                  state_d  = StCalc;
               end
            end
         end
         StCalc: begin
            acc_d    = step_acc;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_rem;
            cnt_d    = cnt_q + 1'b1;
            if (last_step) begin
               state_d  = StDone;
               result_d = sel_result(op_q, step_acc);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Kill wins over everything, including a start in the same cycle.
      if (s_flush_i) begin
         state_d  = StIdle;
         result_d = result_q;
      end
   end

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         state_q  <= StIdle;
         mcand_q  <= '0;
         mplier_q <= '0;
         op_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign s_busy_o   = (state_q == StCalc);
   assign s_done_o   = (state_q == StDone);
   assign s_result_o = result_q;

endmodule
